// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1-style UART transmitter with one-byte holding register; optional parity bit via UART_TX_PARITY_EN
module uart_tx #(
    parameter int DBIT          = 8,
    parameter int S_TICK_LIM    = 16,
    parameter int STOP_BITS_LIM = 16,
    parameter int PARITY_ODD    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    localparam logic [4:0] TICK_LAST = 5'(S_TICK_LIM - 1);
    localparam logic [4:0] STOP_LAST = 5'(STOP_BITS_LIM - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

    if (DBIT < 5 || DBIT > 8) begin : g_bad_dbit
        $error("uart_tx: DBIT must be 5..8");
    end
    if (STOP_BITS_LIM < 1 || STOP_BITS_LIM > 32) begin : g_bad_stop
        $error("uart_tx: STOP_BITS_LIM must be 1..32");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          state, state_n;
    logic [4:0]      tick_cnt, tick_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [DBIT-1:0] shift_reg, shift_n;
    logic [DBIT-1:0] hold_reg, hold_n;
    logic            hold_full, hold_full_n;
    logic            load_shift;
    logic            tx_n;
    logic            done_n;

`ifdef UART_TX_PARITY_EN
    // Copy of the byte in flight; the shift register is consumed by the time parity is sent.
    logic [DBIT-1:0] frame_data;
    logic            parity_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_data <= '0;
        end else if (load_shift) begin
            frame_data <= hold_reg;
        end
    end

    assign parity_bit = (^frame_data) ^ (PARITY_ODD != 0);
`endif

    assign tx_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            tx           <= 1'b1;
            tx_ready     <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_n;
            bit_cnt      <= bit_n;
            shift_reg    <= shift_n;
            hold_reg     <= hold_n;
            hold_full    <= hold_full_n;
            tx           <= tx_n;
            tx_ready     <= !hold_full_n;
            tx_done_tick <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_n      = tick_cnt;
        bit_n       = bit_cnt;
        shift_n     = shift_reg;
        hold_n      = hold_reg;
        hold_full_n = hold_full;
        load_shift  = 1'b0;

        // tx_ready is low whenever holding is full, so capture never collides with a transfer.
        if (tx_start && tx_ready) begin
            hold_n      = data_in[DBIT-1:0];
            hold_full_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    load_shift = 1'b1;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        state_n = ST_DATA;
                    end else begin
                        tick_n = tick_cnt + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        shift_n = shift_reg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end else begin
                            bit_n = bit_cnt + 3'd1;
                        end
                    end else begin
                        tick_n = tick_cnt + 5'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        state_n = ST_STOP;
                    end else begin
                        tick_n = tick_cnt + 5'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_n = '0;
                        if (hold_full) begin
                            load_shift = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 5'd1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Shared by idle and the gapless stop-to-start path.
        if (load_shift) begin
            shift_n     = hold_reg;
            hold_full_n = 1'b0;
            tick_n      = '0;
            bit_n       = '0;
            state_n     = ST_START;
        end
    end

    // Line level is registered from the next state so tx moves on the same edge as the state.
    always_comb begin
        tx_n   = 1'b1;
        done_n = 1'b0;
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_n = parity_bit;
`endif
            default:   tx_n = 1'b1;
        endcase
        if (state == ST_STOP && s_tick && tick_cnt == STOP_LAST) begin
            done_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard and vector-table bench for uart_tx
module tb_uart_tx;

    localparam int BIT   = 256;
    localparam int HALF  = 128;
    localparam int FIRST = BIT + HALF;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int STOP_REL = FIRST + BIT * (8 + PBITS);
    localparam int LOW32    = 16 * (9 + PBITS);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx, tx_ready, tx_busy, tx_done_tick;

    logic       s_tick32 = 1'b1;
    logic       tx_start32 = 1'b0;
    logic [7:0] data_in32 = 8'h00;
    logic       tx32, tx_ready32, tx_busy32, tx_done_tick32;

    int checks = 0;
    int errors = 0;

    uart_tx u_dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .data_in(data_in),
        .tx(tx), .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    uart_tx #(.STOP_BITS_LIM(32)) u_dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick32), .tx_start(tx_start32), .data_in(data_in32),
        .tx(tx32), .tx_ready(tx_ready32), .tx_busy(tx_busy32), .tx_done_tick(tx_done_tick32)
    );

    always #5 clk = ~clk;

    int tick_div = 0;
    always @(posedge clk) begin
        #1;
        tick_div = (tick_div == 15) ? 0 : tick_div + 1;
        s_tick = (tick_div == 15);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: decodes frames from tx and compares against the scoreboard queue.
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         trans_q[$];
    int         done_q[$];
    int         done_count = 0;
    int         cyc = 0;
    logic       prev_tx = 1'b1;
    bit         mon_active = 1'b0;
    int         mon_t0 = 0;
    int         mon_rel = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (tx !== prev_tx) trans_q.push_back(cyc);
            if (tx_done_tick) begin
                done_count++;
                done_q.push_back(cyc);
            end
            if (!mon_active) begin
                if (prev_tx === 1'b1 && tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_t0 = cyc;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_rel = cyc - mon_t0;
                if (mon_rel == HALF) begin
                    check("start_bit", {31'd0, tx}, 32'd0);
                end else if (mon_rel >= FIRST && mon_rel < FIRST + 8 * BIT && (mon_rel - FIRST) % BIT == 0) begin
                    mon_byte[3'((mon_rel - FIRST) / BIT)] = tx;
`ifdef UART_TX_PARITY_EN
                end else if (mon_rel == FIRST + 8 * BIT) begin
                    check("parity_bit", {31'd0, tx}, {31'd0, ^mon_byte});
`endif
                end else if (mon_rel == STOP_REL) begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %02h expected none", mon_byte);
                    end else begin
                        check("frame_data", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                    end
                    mon_active = 1'b0;
                end
            end
        end
        prev_tx = tx;
    end

    task automatic send_byte(input logic [7:0] d, input bit expect_sent);
        @(posedge clk);
        #1;
        tx_start = 1'b1;
        data_in = d;
        if (expect_sent) exp_q.push_back(d);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'd0, done_count >= target}, 32'd1);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'd0, tx_ready}, 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ready_n1;
        logic       ready_n2;
        logic       tx_n2;
        logic       busy_n2;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d0, sq, dq, nt, nd, n, t0;

        vecs[0] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h3B, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_done", {31'd0, tx_done_tick}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            trans_q.delete();
            d0 = done_count;
            send_byte(vecs[i].data, 1'b1);
            @(negedge clk);
            check("ready_n1", {31'd0, tx_ready}, {31'd0, vecs[i].ready_n1});
            @(negedge clk);
            check("ready_n2", {31'd0, tx_ready}, {31'd0, vecs[i].ready_n2});
            check("tx_n2", {31'd0, tx}, {31'd0, vecs[i].tx_n2});
            check("busy_n2", {31'd0, tx_busy}, {31'd0, vecs[i].busy_n2});
            wait_done(d0 + 1, 4000);
            if (vecs[i].data == 8'h55 && PBITS == 0) begin
                check("run_count", trans_q.size(), 32'd10);
                if (trans_q.size() == 10) begin
                    for (int k = 1; k < 9; k++) begin
                        check("bit_len", trans_q[k + 1] - trans_q[k], BIT);
                    end
                    check("stop_len", done_q[done_q.size() - 1] - trans_q[9], BIT);
                end
            end
            repeat (20) @(negedge clk);
            check("idle_tx", {31'd0, tx}, 32'd1);
            check("idle_busy", {31'd0, tx_busy}, 32'd0);
            check("queue_drained", exp_q.size(), 32'd0);
            check("one_done", done_count - d0, 32'd1);
        end

        // Back-to-back frames plus a rejected start while holding is full.
        d0 = done_count;
        sq = start_q.size();
        dq = done_q.size();
        send_byte(8'hA5, 1'b1);
        wait_ready(10);
        send_byte(8'h3C, 1'b1);
        @(negedge clk);
        check("b2b_ready_low", {31'd0, tx_ready}, 32'd0);
        repeat (20) @(negedge clk);
        check("flow_ready_low", {31'd0, tx_ready}, 32'd0);
        send_byte(8'hFF, 1'b0);
        wait_done(d0 + 2, 7000);
        repeat (300) @(negedge clk);
        check("b2b_done_count", done_count - d0, 32'd2);
        check("b2b_frames", start_q.size() - sq, 32'd2);
        if (start_q.size() >= sq + 2 && done_q.size() >= dq + 1) begin
            check("b2b_no_gap", start_q[sq + 1], done_q[dq]);
        end
        check("b2b_queue_drained", exp_q.size(), 32'd0);

        // Reset during data bit 3 of 0x0F with a second byte held.
        sq = start_q.size();
        send_byte(8'h0F, 1'b1);
        wait_ready(10);
        send_byte(8'h99, 1'b1);
        n = 0;
        while (start_q.size() <= sq && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("rst_frame_started", start_q.size() - sq, 32'd1);
        t0 = (start_q.size() > sq) ? start_q[sq] : cyc;
        while (cyc < t0 + FIRST + 3 * BIT) @(negedge clk);
        check("rst_held_before", {31'd0, tx_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        nt = trans_q.size();
        nd = done_count;
        repeat (3000) @(negedge clk);
        check("rst_no_frames", trans_q.size() - nt, 32'd0);
        check("rst_no_done", done_count - nd, 32'd0);
        check("rst_idle_tx", {31'd0, tx}, 32'd1);

        // Two-bit stop period with s_tick held high.
        @(posedge clk);
        #1;
        tx_start32 = 1'b1;
        data_in32 = 8'h00;
        @(posedge clk);
        #1;
        tx_start32 = 1'b0;
        n = 0;
        while (tx32 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("dut32_fall", {31'd0, tx32}, 32'd0);
        n = 0;
        while (tx32 === 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("dut32_low_len", n, LOW32);
        n = 0;
        while (tx_done_tick32 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("dut32_stop_len", n, 32'd32);
        check("dut32_stop_level", {31'd0, tx32}, 32'd1);
        @(negedge clk);
        check("dut32_done_pulse", {31'd0, tx_done_tick32}, 32'd0);
        check("dut32_idle", {31'd0, tx_busy32}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
